// File: rtl/icache_pkg.sv
// Shared encodings and address-field constants for the instruction cache.
// Address layout: {tag, index, offset[1:0], byte bit}.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ADDR_W      = 16;
    localparam int WORD_W      = 16;
    localparam int LINE_WORDS  = 4;
    localparam int OFFSET_BITS = 2;
    localparam int OFFSET_LSB  = 1;
    localparam int INDEX_LSB   = OFFSET_LSB + OFFSET_BITS;

    function automatic int tag_bits(input int index_bits);
        return ADDR_W - INDEX_LSB - index_bits;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for a direct-mapped cache of 4-word lines.
// Latency: combinational read by index/offset; writes land on the next clk edge.
// Backpressure: none; the controller sequences every write.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  idx,
    input  logic [OFFSET_BITS-1:0] rd_off,
    output logic                   rd_valid,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [WORD_W-1:0]      rd_word,
    input  logic                   word_we,
    input  logic [OFFSET_BITS-1:0] wr_off,
    input  logic [WORD_W-1:0]      wr_data,
    input  logic                   tag_we,
    input  logic [TAG_BITS-1:0]    wr_tag,
    input  logic                   inv
);

    localparam int NUM_LINES = 1 << INDEX_BITS;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
    logic [WORD_W-1:0]    data_mem [NUM_LINES*LINE_WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[idx] <= 1'b1;
        end else if (inv) begin
            valid_q[idx] <= 1'b0;
        end
    end

    // Tags and data carry no reset; a cleared valid bit makes them don't-care.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[idx] <= wr_tag;
        end
        if (word_we) begin
            data_mem[{idx, wr_off}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_word  = data_mem[{idx, rd_off}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache; fetch-side Done/Stall responder. ICACHE_STATS_EN adds hit/miss counters.
// Latency: hits and errors complete in the request cycle; misses take the 4-word fill plus one RESP cycle.
// Backpressure: Stall holds fetch during a fill; the backing port advances one word per mem_ack.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              Rd,
    input  logic              Wr,
    output logic [WORD_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int TAG_BITS = tag_bits(INDEX_BITS);
    localparam int TAG_LSB  = INDEX_LSB + INDEX_BITS;

    state_t                  state_q, state_n;
    logic [OFFSET_BITS-1:0]  cnt_q, cnt_n;
    logic [ADDR_W-1:1]       req_q, req_n;
    logic                    drop_q, drop_n;
    logic [WORD_W-1:0]       dout_q;

    logic [TAG_BITS-1:0]     addr_tag, req_tag, rd_tag;
    logic [INDEX_BITS-1:0]   addr_idx, req_idx, line_idx;
    logic [OFFSET_BITS-1:0]  addr_off, req_off, rd_off;
    logic                    rd_valid, word_we, tag_we, inv;
    logic [WORD_W-1:0]       rd_word;

    assign addr_tag = Addr[ADDR_W-1:TAG_LSB];
    assign addr_idx = Addr[TAG_LSB-1:INDEX_LSB];
    assign addr_off = Addr[INDEX_LSB-1:OFFSET_LSB];
    assign req_tag  = req_q[ADDR_W-1:TAG_LSB];
    assign req_idx  = req_q[TAG_LSB-1:INDEX_LSB];
    assign req_off  = req_q[INDEX_LSB-1:OFFSET_LSB];

    // Lookups use the live address only while idle; afterwards the latched request owns the line.
    assign line_idx = (state_q == IDLE) ? addr_idx : req_idx;
    assign rd_off   = (state_q == IDLE) ? addr_off : req_off;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .idx      (line_idx),
        .rd_off   (rd_off),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_word  (rd_word),
        .word_we  (word_we),
        .wr_off   (cnt_q),
        .wr_data  (mem_rdata),
        .tag_we   (tag_we),
        .wr_tag   (req_tag),
        .inv      (inv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            drop_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            req_q   <= req_n;
            drop_q  <= drop_n;
            dout_q  <= DataOut;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        req_n    = req_q;
        drop_n   = drop_q;
        DataOut  = dout_q;
        Done     = 1'b0;
        Stall    = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        mem_req  = 1'b0;
        mem_addr = '0;
        word_we  = 1'b0;
        tag_we   = 1'b0;
        inv      = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (Rd) begin
                        if (Wr || Addr[0]) begin
                            Done    = 1'b1;
                            err     = 1'b1;
                            DataOut = '0;
                        end else if (rd_valid && (rd_tag == addr_tag)) begin
                            Done     = 1'b1;
                            CacheHit = 1'b1;
                            DataOut  = rd_word;
                        end else begin
                            Stall   = 1'b1;
                            inv     = 1'b1;
                            req_n   = Addr[ADDR_W-1:1];
                            cnt_n   = '0;
                            drop_n  = 1'b0;
                            state_n = FILL;
                        end
                    end
                end
                FILL: begin
                    Stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {req_q[ADDR_W-1:INDEX_LSB], cnt_q, 1'b0};
                    if (!Rd) begin
                        drop_n = 1'b1;
                    end
                    if (mem_ack) begin
                        word_we = 1'b1;
                        cnt_n   = cnt_q + 2'd1;
                        if (cnt_q == 2'(LINE_WORDS - 1)) begin
                            tag_we  = 1'b1;
                            state_n = RESP;
                        end
                    end
                end
                RESP: begin
                    state_n = IDLE;
                    if (!drop_q) begin
                        Done    = 1'b1;
                        DataOut = rd_word;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_q, miss_q;
    logic        fill_entry;

    assign fill_entry = (state_q == IDLE) && (state_n == FILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (Done && CacheHit && (hit_q != 16'hFFFF)) begin
                hit_q <= hit_q + 16'd1;
            end
            if (fill_entry && (miss_q != 16'hFFFF)) begin
                miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = 16'h0000;
    assign miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: vector table, hand-written fill/reset corner sequences, random reads vs a cache model.
// Backing memory answers with a random 0-2 cycle delay; word at byte address a is 16'hA000 + (a-16'h0010)/2.
module tb_icache_ctrl;

    localparam int IB     = 5;
    localparam int NLINES = 1 << IB;
`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Addr = '0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, err;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    icache_ctrl #(.INDEX_BITS(IB)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int both_viol = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] t;
        t = a - 16'h0010;
        return 16'hA000 + {1'b0, t[15:1]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Backing memory: random-latency responder, or a raw ack source for the reset corner case.
    logic        mem_auto  = 1'b1;
    logic        stray_ack = 1'b0;
    int          wait_left = 0;
    logic [15:0] ack_addrs [$];

    always @(negedge clk) begin
        if (mem_auto && mem_req) begin
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                ack_addrs.push_back(mem_addr);
                wait_left = $urandom_range(0, 2);
            end else begin
                mem_ack   = 1'b0;
                wait_left = wait_left - 1;
            end
        end else if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hDEAD;
        end else begin
            mem_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        #2;
        if (Done && Stall) both_viol++;
    end

    // Reference model: which tag each line holds, and how many hits/misses fetch should have seen.
    bit m_valid [NLINES];
    int m_tag   [NLINES];
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic model_clear();
        for (int i = 0; i < NLINES; i++) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic model_access(input logic [15:0] a, input logic w,
                                output logic eh, output logic ee, output logic [15:0] ed);
        int idx, tg;
        idx = (int'(a) / 8) % NLINES;
        tg  = int'(a) / (8 * NLINES);
        eh = 1'b0; ee = 1'b0; ed = '0;
        if (w || a[0]) begin
            ee = 1'b1;
        end else begin
            ed = mem_word(a);
            if (m_valid[idx] && m_tag[idx] == tg) begin
                eh = 1'b1;
                exp_hits++;
            end else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                exp_misses++;
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic do_read(input logic [15:0] a, input logic w,
                           output logic [15:0] d, output logic h, output logic e,
                           output int nreq, output int lat, output int stalls);
        int   base;
        logic got;
        base = ack_addrs.size();
        lat = 0; stalls = 0; got = 1'b0; d = '0; h = 1'b0; e = 1'b0;
        @(negedge clk);
        Addr = a; Wr = w; Rd = 1'b1;
        while (!got && lat < 200) begin
            #1;
            if (Done) begin
                got = 1'b1; d = DataOut; h = CacheHit; e = err;
            end else begin
                if (Stall) stalls++;
                @(negedge clk);
                lat++;
            end
        end
        @(negedge clk);
        Rd = 1'b0; Wr = 1'b0;
        nreq = ack_addrs.size() - base;
        chk($sformatf("done_seen_%04h", a), got, 1'b1);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic        exp_hit;
        logic        exp_err;
        logic [15:0] exp_data;
        int          exp_nreq;
    } vec_t;

    vec_t        tbl [8];
    logic [15:0] d, ed;
    logic        h, e, eh, ee, seen;
    int          nreq, lat, stalls, first_base;
    logic [15:0] ra;
    logic        rw;

    initial begin
        tbl[0] = '{16'h0010, 1'b0, 1'b0, 1'b0, 16'hA000, 4};
        tbl[1] = '{16'h0014, 1'b0, 1'b1, 1'b0, 16'hA002, 0};
        tbl[2] = '{16'h0016, 1'b0, 1'b1, 1'b0, 16'hA003, 0};
        tbl[3] = '{16'h0110, 1'b0, 1'b0, 1'b0, 16'hA080, 4};
        tbl[4] = '{16'h0010, 1'b0, 1'b0, 1'b0, 16'hA000, 4};
        tbl[5] = '{16'h0003, 1'b0, 1'b0, 1'b1, 16'h0000, 0};
        tbl[6] = '{16'h0020, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
        tbl[7] = '{16'h0012, 1'b0, 1'b1, 1'b0, 16'hA001, 0};

        reset_dut();
        #1;
        chk("rst_done", Done, 1'b0);
        chk("rst_stall", Stall, 1'b0);
        chk("rst_hit", CacheHit, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_dataout", DataOut, 16'h0000);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_hit_cnt", hit_cnt, 16'h0000);
        chk("rst_miss_cnt", miss_cnt, 16'h0000);

        first_base = ack_addrs.size();
        for (int i = 0; i < 8; i++) begin
            model_access(tbl[i].addr, tbl[i].wr, eh, ee, ed);
            do_read(tbl[i].addr, tbl[i].wr, d, h, e, nreq, lat, stalls);
            chk($sformatf("tbl%0d_hit", i), h, tbl[i].exp_hit);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].exp_err);
            chk($sformatf("tbl%0d_data", i), d, tbl[i].exp_data);
            chk($sformatf("tbl%0d_nreq", i), nreq, tbl[i].exp_nreq);
            if (tbl[i].exp_nreq == 0) chk($sformatf("tbl%0d_same_cycle", i), lat, 0);
            else chk($sformatf("tbl%0d_stall_ge4", i), stalls >= 4, 1'b1);
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("fill_addr%0d", k), ack_addrs[first_base + k], 16'h0010 + 16'(2 * k));

        // Rd dropped and Addr scrambled mid-fill: the fill finishes silently and the line is usable.
        model_access(16'h0240, 1'b0, eh, ee, ed);
        @(negedge clk);
        Addr = 16'h0240; Rd = 1'b1;
        @(negedge clk);
        Rd = 1'b0; Addr = 16'h0001;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (Done) seen = 1'b1;
            @(negedge clk);
        end
        chk("drop_no_done", seen, 1'b0);
        chk("drop_fill_ended", mem_req, 1'b0);
        model_access(16'h0244, 1'b0, eh, ee, ed);
        do_read(16'h0244, 1'b0, d, h, e, nreq, lat, stalls);
        chk("drop_then_hit", h, 1'b1);
        chk("drop_then_data", d, mem_word(16'h0244));

        // Reset during the second fill word, with acks still arriving afterwards.
        mem_auto = 1'b0;
        @(negedge clk);
        Addr = 16'h0010; Rd = 1'b1;
        @(posedge clk); #1;
        Rd = 1'b0; stray_ack = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rstfill_mem_req", mem_req, 1'b0);
        chk("rstfill_stall", Stall, 1'b0);
        chk("rstfill_done", Done, 1'b0);
        chk("rstfill_miss_cnt", miss_cnt, 16'h0000);
        @(posedge clk); #1;
        stray_ack = 1'b0; mem_auto = 1'b1;
        model_clear();
        model_access(16'h0010, 1'b0, eh, ee, ed);
        do_read(16'h0010, 1'b0, d, h, e, nreq, lat, stalls);
        chk("rstfill_remiss_hit", h, 1'b0);
        chk("rstfill_remiss_nreq", nreq, 4);
        chk("rstfill_remiss_data", d, 16'hA000);

        // One miss then three hits on the same line.
        reset_dut();
        do_read(16'h0030, 1'b0, d, h, e, nreq, lat, stalls);
        do_read(16'h0030, 1'b0, d, h, e, nreq, lat, stalls);
        do_read(16'h0032, 1'b0, d, h, e, nreq, lat, stalls);
        do_read(16'h0036, 1'b0, d, h, e, nreq, lat, stalls);
        chk("stats_last_data", d, 16'hA013);
        chk("stats_miss_cnt", miss_cnt, STATS ? 16'd1 : 16'd0);
        chk("stats_hit_cnt", hit_cnt, STATS ? 16'd3 : 16'd0);

        reset_dut();
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom_range(0, 16'h03FF));
            ra[0] = ($urandom_range(0, 7) == 0);
            rw = ($urandom_range(0, 15) == 0);
            model_access(ra, rw, eh, ee, ed);
            do_read(ra, rw, d, h, e, nreq, lat, stalls);
            chk($sformatf("rnd%0d_hit_%04h", i, ra), h, eh);
            chk($sformatf("rnd%0d_err_%04h", i, ra), e, ee);
            chk($sformatf("rnd%0d_data_%04h", i, ra), d, ed);
            chk($sformatf("rnd%0d_nreq_%04h", i, ra), nreq, (eh || ee) ? 0 : 4);
        end
        chk("rnd_hit_cnt", hit_cnt, STATS ? 16'(exp_hits) : 16'd0);
        chk("rnd_miss_cnt", miss_cnt, STATS ? 16'(exp_misses) : 16'd0);
        chk("done_stall_exclusive", both_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
